sysid_boot_checker: RTL
=======================

// Module: sysid_boot_checker
// PURPOSE
//  Avalon-MM read master that sequences the system-ID slave: reads ID (addr 0), then timestamp (addr 1).
//  Compares both words against build-time expected values and reports pass/fail to the CPU and LEDs.
//  Sits beside the sysid slave in the Qsys system; sole master on the sysid control_slave port.
// PARAMETERS
//  EXPECTED_ID      32'd0           expected word at address 0
//  EXPECTED_TS      32'd1490721680  expected word at address 1 (generation timestamp)
//  TIMEOUT_CYCLES   255             consecutive waitrequest cycles before a read is abandoned (>=1)
//  MAX_RETRIES      2               full-sequence retries after a timeout (0..15)
//  AUTO_START       1               1: check launches automatically once after reset release
//  RECHECK_PERIOD   50_000_000      cycles between periodic checks (used only with SYSID_RECHECK_EN)
// PORTS
//  clock            in   1   system clock
//  reset            in   1   asynchronous, active-high reset
//  start            in   1   pulse: launch a check; ignored while busy=1
//  avm_address      out  1   sysid word select
//  avm_read         out  1   Avalon read strobe
//  avm_readdata     in   32  read data, valid when avm_read=1 && avm_waitrequest=0
//  avm_waitrequest  in   1   slave stall
//  busy             out  1   check in progress
//  done             out  1   one-cycle pulse when a check finishes
//  pass             out  1   last check matched both words (held)
//  fail_code        out  2   00 none, 01 ID mismatch, 10 TS mismatch, 11 timeout (held)
//  id_value         out  32  last captured ID word
//  ts_value         out  32  last captured timestamp word
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; retry and timeout counters 0. Async assert drops avm_read immediately.
//  FSM: IDLE -> RD_ID -> RD_TS -> CHECK -> IDLE.
//   IDLE: on start (or first cycle after reset release if AUTO_START=1) -> RD_ID; clear pass, fail_code, retries.
//   RD_ID/RD_TS: avm_read=1, avm_address=0/1. Transfer ends in cycle with waitrequest=0: capture readdata into
//    id_value/ts_value, advance. avm_read and avm_address change only on transfer end or timeout.
//   CHECK: id_value!=EXPECTED_ID -> fail 01 (priority); else ts mismatch -> 10; else pass=1.
//    done=1 for this cycle; -> IDLE.
//  Latency with waitrequest=0: start at cycle N -> RD_ID N+1, RD_TS N+2, CHECK/done N+3.
//  Timeout: wait counter increments each read cycle with waitrequest=1, clears on state change.
//   Reaching TIMEOUT_CYCLES: avm_read=0 for one cycle, then RD_ID if retries<MAX_RETRIES (retries++),
//   else done=1, fail_code=11, pass=0 -> IDLE.
//  start while busy: ignored, no queuing. start with AUTO_START trigger same cycle: one check only.
//  busy=1 in every non-IDLE state including the one-cycle read gap after timeout.
// CONFIGURATION
//  SYSID_RECHECK_EN defined: free-running period counter; on reaching RECHECK_PERIOD-1 in IDLE,
//   launches check as if start; counter restarts at 0 on every launch; pulse during busy deferred to IDLE.
//  Undefined: no period counter; checks only on start/AUTO_START; RECHECK_PERIOD unused.
// STRUCTURE
//  Package sysid_ctrl_pkg: state enum (IDLE,RD_ID,RD_TS,CHECK,GAP), fail-code localparams
//   FAIL_NONE/FAIL_ID/FAIL_TS/FAIL_TIMEOUT, SYSID_ADDR_ID=0, SYSID_ADDR_TS=1.
//  Sub-module sysid_wait_timer: load/clear, increment-on-stall, expired flag; width $clog2(TIMEOUT_CYCLES+1).
// TESTING
//  1 Reset release, AUTO_START=1, waitrequest=0, slave returns 0/1490721680 -> done at cycle 3, pass=1, code 00.
//  2 start, addr0 returns 32'h0000_0001 -> pass=0, fail_code=01, id_value=1, ts still read.
//  3 waitrequest=1 for 3 cycles in RD_TS -> address/read stable, done delayed 3 cycles, pass=1.
//  4 waitrequest stuck high, TIMEOUT_CYCLES=4, MAX_RETRIES=2 -> 3 attempts, done, fail_code=11.
//  5 start pulse while busy -> ignored, exactly one done; reset mid-RD_TS -> avm_read=0 same cycle.
//  6 SYSID_RECHECK_EN, RECHECK_PERIOD=100 -> checks launched every 100 cycles, each gives done pulse.

Source files
------------

// File: rtl/sysid_ctrl_pkg.sv
// ============================================================================
// Module : sysid_ctrl_pkg
// Brief  : Shared types and constants for the system-ID boot checker.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sysid_ctrl_pkg;

    // Checker sequencing states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_ID = 3'd1,
        RD_TS = 3'd2,
        CHECK = 3'd3,
        GAP   = 3'd4
    } state_t;

    // Result codes reported on fail_code
    localparam logic [1:0] FAIL_NONE    = 2'b00;
    localparam logic [1:0] FAIL_ID      = 2'b01;
    localparam logic [1:0] FAIL_TS      = 2'b10;
    localparam logic [1:0] FAIL_TIMEOUT = 2'b11;

    // Word select values on the sysid control slave
    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    // ID mismatch takes priority over a timestamp mismatch.
    function automatic logic [1:0] classify_words(
        input logic [31:0] id_word,
        input logic [31:0] ts_word,
        input logic [31:0] exp_id,
        input logic [31:0] exp_ts
    );
        logic [1:0] code;
        code = FAIL_NONE;
        if (id_word != exp_id) begin
            code = FAIL_ID;
        end else if (ts_word != exp_ts) begin
            code = FAIL_TS;
        end
        return code;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sysid_wait_timer.sv
// ============================================================================
// Module : sysid_wait_timer
// Brief  : Counts consecutive stalled read cycles and flags the cycle in which
//          the stall count reaches TIMEOUT_CYCLES.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sysid_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear_i,
    input  logic stall_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear dominates; otherwise count every stalled read cycle
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (stall_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Stall counter register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // This stalled cycle is the TIMEOUT_CYCLES-th in a row
    assign expired_o = stall_i && (cnt_q == CNT_LAST);

endmodule

`default_nettype wire

// File: rtl/sysid_boot_checker.sv
// ============================================================================
// Module : sysid_boot_checker
// Brief  : Avalon-MM read master that reads the sysid ID word (addr 0) and
//          timestamp (addr 1), compares them with build-time values and
//          reports pass/fail. Optional periodic re-check is enabled by
//          defining SYSID_RECHECK_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sysid_boot_checker
    import sysid_ctrl_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1490721680,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned MAX_RETRIES    = 2,
    parameter int unsigned AUTO_START     = 1,
    parameter int unsigned RECHECK_PERIOD = 50_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [1:0]  fail_code,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam logic [3:0] MAX_RETRY_CNT = 4'(MAX_RETRIES);

    state_t      state_q, state_d;
    logic [3:0]  retries_q, retries_d;
    logic        auto_q;
    logic        pass_q, pass_d;
    logic [1:0]  code_q, code_d;
    logic [31:0] id_q, id_d;
    logic [31:0] ts_q, ts_d;

    logic w_reading;
    logic w_stall;
    logic w_expired;
    logic w_timer_clear;
    logic w_recheck;
    logic w_launch;
    logic w_retries_left;

    assign w_reading      = (state_q == RD_ID) || (state_q == RD_TS);
    assign w_stall        = w_reading && avm_waitrequest;
    assign w_timer_clear  = (state_d != state_q) || !w_reading;
    assign w_retries_left = (retries_q < MAX_RETRY_CNT);
    assign w_launch       = (state_q == IDLE) && (start || auto_q || w_recheck);

    sysid_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clock     (clock),
        .reset     (reset),
        .clear_i   (w_timer_clear),
        .stall_i   (w_stall),
        .expired_o (w_expired)
    );

`ifdef SYSID_RECHECK_EN
    localparam logic [31:0] PERIOD_LAST = 32'(RECHECK_PERIOD - 1);

    logic [31:0] period_q;
    logic        recheck_pend_q;

    // A period expiry seen while busy is remembered until IDLE
    assign w_recheck = recheck_pend_q || (period_q == PERIOD_LAST);

    // Free-running period counter, restarted by every launch
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            period_q       <= 32'd0;
            recheck_pend_q <= 1'b0;
        end else if (w_launch) begin
            period_q       <= 32'd0;
            recheck_pend_q <= 1'b0;
        end else if (period_q == PERIOD_LAST) begin
            period_q       <= 32'd0;
            recheck_pend_q <= 1'b1;
        end else begin
            period_q       <= period_q + 32'd1;
        end
    end
`else
    assign w_recheck = 1'b0;

    // RECHECK_PERIOD has no effect without the periodic re-check
    if (RECHECK_PERIOD == 0) begin : g_recheck_off
    end
`endif

    // Next-state, result and capture logic
    always_comb begin
        state_d   = state_q;
        retries_d = retries_q;
        pass_d    = pass_q;
        code_d    = code_q;
        id_d      = id_q;
        ts_d      = ts_q;
        unique case (state_q)
            IDLE: begin
                if (w_launch) begin
                    state_d   = RD_ID;
                    pass_d    = 1'b0;
                    code_d    = FAIL_NONE;
                    retries_d = 4'd0;
                end
            end
            RD_ID: begin
                if (w_expired) begin
                    state_d = GAP;
                    if (!w_retries_left) begin
                        code_d = FAIL_TIMEOUT;
                        pass_d = 1'b0;
                    end
                end else if (!avm_waitrequest) begin
                    id_d    = avm_readdata;
                    state_d = RD_TS;
                end
            end
            RD_TS: begin
                if (w_expired) begin
                    state_d = GAP;
                    if (!w_retries_left) begin
                        code_d = FAIL_TIMEOUT;
                        pass_d = 1'b0;
                    end
                end else if (!avm_waitrequest) begin
                    // Result is registered on entry so it is valid with done
                    ts_d    = avm_readdata;
                    code_d  = classify_words(id_q, avm_readdata, EXPECTED_ID, EXPECTED_TS);
                    pass_d  = (classify_words(id_q, avm_readdata, EXPECTED_ID, EXPECTED_TS) == FAIL_NONE);
                    state_d = CHECK;
                end
            end
            CHECK: begin
                state_d = IDLE;
            end
            GAP: begin
                if (w_retries_left) begin
                    retries_d = retries_q + 4'd1;
                    state_d   = RD_ID;
                end else begin
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers; auto-start flag lives for one cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            retries_q <= 4'd0;
            auto_q    <= (AUTO_START != 0);
            pass_q    <= 1'b0;
            code_q    <= FAIL_NONE;
            id_q      <= 32'd0;
            ts_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            retries_q <= retries_d;
            auto_q    <= 1'b0;
            pass_q    <= pass_d;
            code_q    <= code_d;
            id_q      <= id_d;
            ts_q      <= ts_d;
        end
    end

    // Bus strobes come straight from state so reset drops them at once
    assign avm_read    = w_reading;
    assign avm_address = (state_q == RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == CHECK) || ((state_q == GAP) && !w_retries_left);
    assign pass        = pass_q;
    assign fail_code   = code_q;
    assign id_value    = id_q;
    assign ts_value    = ts_q;

endmodule

`default_nettype wire
